// File: rtl/i2c_config_sequencer.sv
// Sequencer that walks a table of 24-bit I2C write words, issuing one I2C_control
// transaction per entry with NACK retry, completion timeout and done/error status.
module i2c_config_sequencer #(
    parameter int unsigned NUM_REGS      = 11,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned TIMEOUT       = 1023
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [23:0]       tbl_data,
    output logic [23:0]       i2c_data,
    output logic              i2c_go,
    input  logic              i2c_done,
    input  logic              i2c_nack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_index
);

    localparam int unsigned TMAX = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_GO,
        S_WAIT,
        S_SETTLE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] tbl_addr_q, tbl_addr_d;
    logic [23:0]       i2c_data_q, i2c_data_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              redo_q, redo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] err_index_q, err_index_d;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            tbl_addr_q  <= '0;
            i2c_data_q  <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            redo_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            tbl_addr_q  <= tbl_addr_d;
            i2c_data_q  <= i2c_data_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            redo_q      <= redo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
        end
    end

    // tbl_addr is loaded on entry to FETCH so a registered ROM has its word ready by LOAD.
    // Status flags are set on the transition into DONE/ERROR, which fixes the timeout latency.
    always_comb begin
        state_d     = state_q;
        tbl_addr_d  = tbl_addr_q;
        i2c_data_d  = i2c_data_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        redo_d      = redo_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_index_d = err_index_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    idx_d      = '0;
                    tbl_addr_d = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_FETCH: begin
                tbl_addr_d = idx_q;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                i2c_data_d = tbl_data;
                retry_d    = '0;
                redo_d     = 1'b0;
                state_d    = S_GO;
            end
            S_GO: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (i2c_done) begin
                    if (!i2c_nack) begin
                        redo_d  = 1'b0;
                        timer_d = '0;
                        state_d = S_SETTLE;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        redo_d  = 1'b1;
                        timer_d = '0;
                        state_d = S_SETTLE;
                    end else begin
                        error_d     = 1'b1;
                        busy_d      = 1'b0;
                        err_index_d = idx_q;
                        state_d     = S_ERROR;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    error_d     = 1'b1;
                    busy_d      = 1'b0;
                    err_index_d = idx_q;
                    state_d     = S_ERROR;
                end
            end
            S_SETTLE: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
                    if (redo_q) begin
                        state_d = S_GO;
                    end else if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        idx_d      = idx_q + ADDR_W'(1);
                        tbl_addr_d = idx_q + ADDR_W'(1);
                        state_d    = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign tbl_addr  = tbl_addr_q;
    assign i2c_data  = i2c_data_q;
    assign i2c_go    = (state_q == S_GO);
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_index = err_index_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Scoreboard bench for i2c_config_sequencer: a per-run model predicts the GO word
// sequence and final status; a negedge monitor pops and compares as the DUT acts.
module tb_i2c_config_sequencer;

    localparam int unsigned NUM_REGS      = 11;
    localparam int unsigned ADDR_W        = 4;
    localparam int unsigned MAX_RETRY     = 3;
    localparam int unsigned SETTLE_CYCLES = 16;
    localparam int unsigned TIMEOUT       = 1023;
    localparam int          NEVER         = 1000;

    logic              CLK = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] tbl_addr;
    logic [23:0]       tbl_data = '0;
    logic [23:0]       i2c_data;
    logic              i2c_go;
    logic              i2c_done = 1'b0;
    logic              i2c_nack = 1'b0;
    logic              busy, done, error;
    logic [ADDR_W-1:0] err_index;

    i2c_config_sequencer #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W(ADDR_W),
        .MAX_RETRY(MAX_RETRY),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .start(start),
        .tbl_addr(tbl_addr),
        .tbl_data(tbl_data),
        .i2c_data(i2c_data),
        .i2c_go(i2c_go),
        .i2c_done(i2c_done),
        .i2c_nack(i2c_nack),
        .busy(busy),
        .done(done),
        .error(error),
        .err_index(err_index)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    logic [23:0] rom [2**ADDR_W];
    always @(posedge CLK) tbl_data <= rom[tbl_addr];

    typedef struct {
        int          idx;
        logic [23:0] data;
    } go_t;
    typedef struct {
        bit done;
        bit err;
        int err_idx;
        int max_addr;
        bit tmo;
    } end_t;

    go_t  exp_go_q[$];
    end_t exp_end_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Slave-side stimulus: number of NACKs each entry returns before ACKing.
    int plan [NUM_REGS];
    int resp_e = 0, resp_t = 0;
    bit stray_en = 1'b0;

    // Reference model: expected GO sequence and final status from the plan alone.
    task automatic build_expect();
        end_t r;
        r = '{done: 1'b1, err: 1'b0, err_idx: 0, max_addr: NUM_REGS - 1, tmo: 1'b0};
        for (int i = 0; i < NUM_REGS; i++) begin
            int tries;
            if (plan[i] == NEVER) tries = 1;
            else if (plan[i] <= MAX_RETRY) tries = plan[i] + 1;
            else tries = MAX_RETRY + 1;
            for (int t = 0; t < tries; t++) exp_go_q.push_back('{idx: i, data: rom[i]});
            if (plan[i] == NEVER || plan[i] > MAX_RETRY) begin
                r = '{done: 1'b0, err: 1'b1, err_idx: i, max_addr: i, tmo: (plan[i] == NEVER)};
                break;
            end
        end
        exp_end_q.push_back(r);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (i2c_go && resp_e < NUM_REGS && plan[resp_e] != NEVER) begin
                bit nk;
                int lat;
                nk = (resp_t < plan[resp_e]);
                if (nk) resp_t++;
                else begin
                    resp_e++;
                    resp_t = 0;
                end
                lat = $urandom_range(5, 40);
                repeat (lat - 1) @(negedge CLK);
                i2c_done = 1'b1;
                i2c_nack = nk;
                @(negedge CLK);
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
                if (stray_en) begin
                    repeat (4) @(negedge CLK);
                    i2c_done = 1'b1;
                    i2c_nack = 1'($urandom);
                    @(negedge CLK);
                    i2c_done = 1'b0;
                    i2c_nack = 1'b0;
                end
            end
        end
    end

    bit mon_en = 1'b1;
    bit first_go = 1'b0;
    bit prev_busy = 1'b0;
    int start_cyc = 0;
    int last_go_cyc = 0;
    int max_addr_seen = 0;
    int go_count = 0;

    always @(negedge CLK) begin
        if (i2c_go) go_count++;
        if (mon_en) begin
            if (busy && int'(tbl_addr) > max_addr_seen) max_addr_seen = int'(tbl_addr);
            if (i2c_go) begin
                if (exp_go_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_go actual=idx%0d expected=no GO", tbl_addr);
                end else begin
                    go_t g;
                    g = exp_go_q.pop_front();
                    chk("go_tbl_addr", tbl_addr, g.idx);
                    chk("go_i2c_data", i2c_data, g.data);
                    if (first_go) begin
                        chk("start_to_go_latency", cyc - start_cyc, 3);
                        first_go = 1'b0;
                    end
                end
                last_go_cyc = cyc;
            end
            if (prev_busy && !busy) begin
                if (exp_end_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_end actual=busy fell expected=still busy");
                end else begin
                    end_t e;
                    e = exp_end_q.pop_front();
                    chk("end_done", done, e.done);
                    chk("end_error", error, e.err);
                    if (e.err) chk("end_err_index", err_index, e.err_idx);
                    chk("end_max_tbl_addr", max_addr_seen, e.max_addr);
                    if (e.tmo) chk("timeout_latency", cyc - last_go_cyc, TIMEOUT + 1);
                end
            end
        end
        prev_busy = busy;
    end

    task automatic new_rom();
        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = 24'($urandom);
    endtask

    task automatic do_run(input bit stray, input bit extra_start);
        int k;
        build_expect();
        resp_e = 0;
        resp_t = 0;
        stray_en = stray;
        max_addr_seen = 0;
        first_go = 1'b1;
        @(negedge CLK);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge CLK);
        start = 1'b0;
        for (k = 0; k < 30000; k++) begin
            @(negedge CLK);
            if (extra_start && k == 100) start = 1'b1;
            if (extra_start && k == 101) start = 1'b0;
            if (!busy) break;
        end
        if (k == 30000) chk("run_completion_bound", k, -1);
        repeat (5) @(negedge CLK);
        chk("leftover_go", exp_go_q.size(), 0);
        chk("leftover_end", exp_end_q.size(), 0);
        exp_go_q.delete();
        exp_end_q.delete();
        stray_en = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tbl_addr"}, tbl_addr, 0);
        chk({tag, "_i2c_data"}, i2c_data, 0);
        chk({tag, "_i2c_go"}, i2c_go, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_err_index"}, err_index, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        new_rom();
        foreach (plan[i]) plan[i] = 0;
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        check_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge CLK);

        // 1: clean run
        do_run(1'b0, 1'b0);
        chk("s1_done_flag", done, 1);

        // 2: entry 4 NACKed twice
        new_rom();
        plan[4] = 2;
        do_run(1'b0, 1'b0);
        plan[4] = 0;

        // 3: entry 2 always NACKed
        new_rom();
        plan[2] = 100;
        do_run(1'b0, 1'b0);
        chk("s3_err_index", err_index, 2);
        plan[2] = 0;

        // 4: no completion on entry 0
        new_rom();
        plan[0] = NEVER;
        do_run(1'b0, 1'b0);
        plan[0] = 0;

        // 5: reset during WAIT of entry 5, then a fresh run
        new_rom();
        mon_en = 1'b0;
        resp_e = 0;
        resp_t = 0;
        go_count = 0;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (k = 0; k < 5000 && go_count < 6; k++) @(negedge CLK);
        chk("s5_reach_entry5", go_count, 6);
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        check_zero("s5_after_reset");
        reset = 1'b1;
        repeat (60) @(negedge CLK);
        mon_en = 1'b1;
        do_run(1'b0, 1'b0);

        // 6: start while busy plus stray completions in SETTLE
        new_rom();
        do_run(1'b1, 1'b1);
        chk("s6_done_flag", done, 1);

        // randomized plans
        for (int r = 0; r < 4; r++) begin
            new_rom();
            foreach (plan[i]) begin
                int x;
                x = $urandom_range(0, 19);
                plan[i] = (x < 14) ? 0 : (x < 17) ? 1 : (x < 19) ? 3 : 7;
            end
            do_run(1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
